bfn_train_ctrl: RTL and testbench

- Training sequencer for the bias-free neural predictor's perceptron table.
- Buffers each in-flight prediction: 16 table indices, 16 weights read, 16 history bits, perceptron sum.
- On branch resolution, pops the oldest entry and decides whether to train.
- When training, computes saturating weight updates and drives the table's update port (index_update, perceptron_weights_update, en_2) for one cycle.

---
 rtl/bfn_pkg.sv | 58 +++++
 rtl/bfn_inflight_fifo.sv | 70 +++++++
 rtl/bfn_train_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bfn_train_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfn_pkg.sv
// bfn_pkg: shared constants, types and the saturating weight-update
// helper for the bias-free perceptron training sequencer.
package bfn_pkg;

   localparam int NUM_W    = 16;
   localparam int W_BITS   = 3;
   localparam int IDX_BITS = 10;
   localparam int SUM_BITS = 7;

   typedef logic signed [W_BITS-1:0]   weight_t;
   typedef logic signed [SUM_BITS-1:0] sum_t;

   typedef logic [NUM_W*IDX_BITS-1:0] idx_vec_t;
   typedef logic [NUM_W*W_BITS-1:0]   w_vec_t;
   typedef logic [NUM_W-1:0]          hist_t;

   typedef struct packed {
      idx_vec_t index;
      w_vec_t   weights;
      hist_t    hist;
      sum_t     sum;
   } pred_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_WRITE
   } state_t;

   localparam weight_t W_MAX = 3'b011;
   localparam weight_t W_MIN = 3'b100;

   // Agreeing history bit strengthens the weight toward the outcome.
   function automatic w_vec_t train_weights(
      input w_vec_t w,
      input hist_t  h,
      input logic   t
   );
      w_vec_t  res;
      weight_t wi;
      res = '0;
      for (int i = 0; i < NUM_W; i++) begin
         wi = w[i*W_BITS +: W_BITS];
         if (h[i] == t) begin
            if (wi != W_MAX) begin
               wi = wi + 3'sd1;
            end
         end else begin
            if (wi != W_MIN) begin
               wi = wi - 3'sd1;
            end
         end
         res[i*W_BITS +: W_BITS] = wi;
      end
      return res;
   endfunction

endpackage

// File: rtl/bfn_inflight_fifo.sv
// bfn_inflight_fifo: circular buffer of in-flight predictions with
// flush, occupancy and full/empty flags.
module bfn_inflight_fifo
   import bfn_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_flush,
   input  pred_entry_t i_data,
   output pred_entry_t o_data,
   output logic        o_full,
   output logic        o_empty,
   output logic [AW:0] o_occupancy
);

   pred_entry_t r_mem [DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);

   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   assign o_data      = r_mem[r_rd_ptr];
   assign o_occupancy = r_count;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/bfn_train_ctrl.sv
// bfn_train_ctrl: buffers predictions, evaluates each resolution and
// drives one-cycle table updates. Optional macro: BFN_ADAPTIVE_THETA_EN.
module bfn_train_ctrl
   import bfn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int THETA = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pred_valid,
   output logic                     pred_ready,
   input  logic [159:0]             pred_index,
   input  logic [47:0]              pred_weights,
   input  logic [15:0]              pred_hist,
   input  logic [6:0]               pred_sum,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic                     res_taken,
   input  logic                     flush,
   output logic                     upd_en,
   output logic [159:0]             upd_index,
   output logic [47:0]              upd_weights,
   output logic                     upd_mispredict,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [6:0]               theta_cur
);

   state_t      r_state;
   pred_entry_t r_entry;
   logic        r_taken;
   w_vec_t      r_new_w;
   logic        r_upd_en;
   idx_vec_t    r_upd_idx;
   w_vec_t      r_upd_w;
   logic        r_mis;

   pred_entry_t w_wr_entry;
   pred_entry_t w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic [6:0]  w_theta;
   logic [7:0]  w_sum8;
   logic [7:0]  w_abs;
   logic        w_pred_t;
   logic        w_mis;
   logic        w_train;
   w_vec_t      w_new_w;

   assign w_wr_entry.index   = pred_index;
   assign w_wr_entry.weights = pred_weights;
   assign w_wr_entry.hist    = pred_hist;
   assign w_wr_entry.sum     = pred_sum;

   assign pred_ready = !w_full && !flush;
   assign res_ready  = (r_state == ST_IDLE)
                     && !w_empty && !flush;

   assign w_push = pred_valid && pred_ready;
   assign w_pop  = res_valid && res_ready;

   bfn_inflight_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_flush     (flush),
      .i_data      (w_wr_entry),
      .o_data      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_occupancy (occupancy)
   );

   // Widen to 8 bits so the most negative sum has a representable magnitude.
   assign w_sum8 = {r_entry.sum[SUM_BITS-1], r_entry.sum};
   assign w_abs  = w_sum8[7] ? (8'd0 - w_sum8) : w_sum8;

   assign w_pred_t = !r_entry.sum[SUM_BITS-1];
   assign w_mis    = (w_pred_t != r_taken);
   assign w_train  = w_mis || (w_abs <= {1'b0, w_theta});
   assign w_new_w  = train_weights(r_entry.weights,
                                   r_entry.hist,
                                   r_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_entry   <= '0;
         r_taken   <= 1'b0;
         r_new_w   <= '0;
         r_upd_en  <= 1'b0;
         r_upd_idx <= '0;
         r_upd_w   <= '0;
         r_mis     <= 1'b0;
      end else begin
         r_upd_en <= 1'b0;
         r_mis    <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_entry <= w_head;
                  r_taken <= res_taken;
                  r_state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               r_mis   <= w_mis;
               r_new_w <= w_new_w;
               r_state <= w_train ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
               r_upd_en  <= 1'b1;
               r_upd_idx <= r_entry.index;
               r_upd_w   <= r_new_w;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BFN_ADAPTIVE_THETA_EN
   logic signed [4:0] r_tc;
   logic [6:0]        r_theta;

   assign w_theta = r_theta;

   // The counter restarts whenever it reaches either end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tc    <= '0;
         r_theta <= 7'(THETA);
      end else if (r_state == ST_EVAL) begin
         if (w_mis) begin
            if (r_tc == 5'sd14) begin
               r_tc <= '0;
               if (r_theta != 7'd63) begin
                  r_theta <= r_theta + 7'd1;
               end
            end else begin
               r_tc <= r_tc + 5'sd1;
            end
         end else if (w_train) begin
            if (r_tc == -5'sd15) begin
               r_tc <= '0;
               if (r_theta != 7'd0) begin
                  r_theta <= r_theta - 7'd1;
               end
            end else begin
               r_tc <= r_tc - 5'sd1;
            end
         end
      end
   end
`else
   assign w_theta = 7'(THETA);
`endif

   assign upd_en         = r_upd_en;
   assign upd_index      = r_upd_idx;
   assign upd_weights    = r_upd_w;
   assign upd_mispredict = r_mis;
   assign theta_cur      = w_theta;

endmodule

// File: tb/tb_bfn_train_ctrl.sv
// tb_bfn_train_ctrl: vector table, hand sequences and randomized
// resolutions checked against an integer reference model.
module tb_bfn_train_ctrl;

   localparam int DEPTH = 4;
   localparam int THETA = 14;

   logic         clk;
   logic         rst;
   logic         pred_valid;
   logic         pred_ready;
   logic [159:0] pred_index;
   logic [47:0]  pred_weights;
   logic [15:0]  pred_hist;
   logic [6:0]   pred_sum;
   logic         res_valid;
   logic         res_ready;
   logic         res_taken;
   logic         flush;
   logic         upd_en;
   logic [159:0] upd_index;
   logic [47:0]  upd_weights;
   logic         upd_mispredict;
   logic [2:0]   occupancy;
   logic [6:0]   theta_cur;

   int n_err = 0;
   int n_chk = 0;

   bfn_train_ctrl #(
      .DEPTH (DEPTH),
      .THETA (THETA)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pred_valid     (pred_valid),
      .pred_ready     (pred_ready),
      .pred_index     (pred_index),
      .pred_weights   (pred_weights),
      .pred_hist      (pred_hist),
      .pred_sum       (pred_sum),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_taken      (res_taken),
      .flush          (flush),
      .upd_en         (upd_en),
      .upd_index      (upd_index),
      .upd_weights    (upd_weights),
      .upd_mispredict (upd_mispredict),
      .occupancy      (occupancy),
      .theta_cur      (theta_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  sum;
      logic [47:0] w;
      logic [15:0] h;
      logic        t;
      logic        mis;
      logic        tr;
      logic [47:0] nw;
   } vec_t;

   vec_t tv [12];

   task automatic chk(input string nm,
                      input logic [159:0] act,
                      input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the training rules.
   task automatic model(input logic [6:0] s,
                        input logic t,
                        input logic [47:0] w,
                        input logic [15:0] h,
                        output logic mis,
                        output logic tr,
                        output logic [47:0] nw);
      int sv;
      int a;
      int wi;
      sv  = int'($signed(s));
      a   = (sv < 0) ? -sv : sv;
      mis = ((sv >= 0) != t);
      tr  = mis || (a <= THETA);
      nw  = '0;
      for (int i = 0; i < 16; i++) begin
         wi = int'($signed(w[i*3 +: 3]));
         wi = (h[i] == t) ? wi + 1 : wi - 1;
         if (wi > 3) wi = 3;
         if (wi < -4) wi = -4;
         nw[i*3 +: 3] = wi[2:0];
      end
   endtask

   task automatic push(input logic [159:0] idx,
                       input logic [47:0] w,
                       input logic [15:0] h,
                       input logic [6:0] s);
      pred_valid   = 1'b1;
      pred_index   = idx;
      pred_weights = w;
      pred_hist    = h;
      pred_sum     = s;
      step();
      pred_valid = 1'b0;
   endtask

   task automatic wait_res_ready(input string nm);
      int k;
      k = 0;
      while (!res_ready && k < 10) begin
         step();
         k++;
      end
      if (!res_ready) chk({nm, ".timeout"}, 0, 1);
   endtask

   task automatic run_one(input string nm,
                          input logic [159:0] idx,
                          input logic [47:0] w,
                          input logic [15:0] h,
                          input logic [6:0] s,
                          input logic t,
                          input logic emis,
                          input logic etr,
                          input logic [47:0] enw);
      push(idx, w, h, s);
      wait_res_ready(nm);
      res_valid = 1'b1;
      res_taken = t;
      step();
      res_valid = 1'b0;
      step();
      chk({nm, ".mis"}, upd_mispredict, emis);
      chk({nm, ".en_early"}, upd_en, 0);
      step();
      chk({nm, ".en"}, upd_en, etr);
      if (etr) begin
         chk({nm, ".w"}, upd_weights, enw);
         chk({nm, ".idx"}, upd_index, idx);
      end
      step();
      chk({nm, ".en_off"}, upd_en, 0);
   endtask

   function automatic logic [159:0] rnd160();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [159:0] idx0;
   logic         m_mis;
   logic         m_tr;
   logic [47:0]  m_nw;
   logic [47:0]  rw;
   logic [15:0]  rh;
   logic [6:0]   rs;
   logic         rt;

   initial begin
      tv[0]  = '{7'h6C, 48'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 48'h249249249249};
      tv[1]  = '{7'd30, 48'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 48'h0};
      tv[2]  = '{7'd10, 48'h0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 48'h249249249249};
      tv[3]  = '{7'd5, 48'h8E38E38E38E3, 16'hFFFF, 1'b1, 1'b0, 1'b1, 48'hAEBAEBAEBAEB};
      tv[4]  = '{7'd5, 48'h8E38E38E38E3, 16'h0000, 1'b1, 1'b0, 1'b1, 48'h8A28A28A28A2};
      tv[5]  = '{7'h40, 48'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 48'h0};
      tv[6]  = '{7'd14, 48'h0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 48'h249249249249};
      tv[7]  = '{7'd15, 48'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 48'h0};
      tv[8]  = '{7'h72, 48'h0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 48'hFFFFFFFFFFFF};
      tv[9]  = '{7'd0, 48'h0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 48'hFFFFFFFFFFFF};
      tv[10] = '{7'h7F, 48'h8E38E38E38E3, 16'h0000, 1'b0, 1'b0, 1'b1, 48'hAEBAEBAEBAEB};
      tv[11] = '{7'h3F, 48'h0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 48'hFFFFFFFFFFFF};

      rst = 1'b1;
      pred_valid = 1'b0;
      pred_index = '0;
      pred_weights = '0;
      pred_hist = '0;
      pred_sum = '0;
      res_valid = 1'b0;
      res_taken = 1'b0;
      flush = 1'b0;
      repeat (2) step();
      chk("rst.occ", occupancy, 0);
      chk("rst.en", upd_en, 0);
      chk("rst.mis", upd_mispredict, 0);
      chk("rst.idx", upd_index, 0);
      chk("rst.theta", theta_cur, THETA);
      chk("rst.res_ready", res_ready, 0);
      rst = 1'b0;
      step();
      chk("idle.pred_ready", pred_ready, 1);

      // Fill the buffer, offer a fifth, then resolve one.
      pred_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pred_index = rnd160();
         pred_sum = 7'd40;
         step();
      end
      chk("full.occ", occupancy, 4);
      chk("full.ready", pred_ready, 0);
      step();
      chk("full.no5th", occupancy, 4);
      pred_valid = 1'b0;
      res_valid = 1'b1;
      res_taken = 1'b1;
      step();
      res_valid = 1'b0;
      chk("pop.ready", pred_ready, 1);
      chk("pop.occ", occupancy, 3);
      repeat (3) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush1.occ", occupancy, 0);

      foreach (tv[i]) begin
         run_one($sformatf("tv%0d", i), rnd160(),
                 tv[i].w, tv[i].h, tv[i].sum, tv[i].t,
                 tv[i].mis, tv[i].tr, tv[i].nw);
      end

      // Flush while an update is in EVAL: it must still complete.
      idx0 = rnd160();
      push(idx0, 48'h0, 16'hFFFF, 7'h6C);
      push(rnd160(), 48'h0, 16'h0, 7'd1);
      push(rnd160(), 48'h0, 16'h0, 7'd1);
      res_valid = 1'b1;
      res_taken = 1'b1;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      res_valid = 1'b0;
      chk("fl.occ", occupancy, 0);
      chk("fl.mis", upd_mispredict, 1);
      step();
      chk("fl.en", upd_en, 1);
      chk("fl.w", upd_weights, 48'h249249249249);
      chk("fl.idx", upd_index, idx0);
      res_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl.res_ready", res_ready, 0);
      end
      chk("fl.no_mis", upd_mispredict, 0);
      chk("fl.no_en", upd_en, 0);
      res_valid = 1'b0;

      for (int n = 0; n < 60; n++) begin
         rw = {$urandom, $urandom};
         rh = $urandom;
         rs = $urandom;
         rt = $urandom;
         if (n % 3 == 0) rs = 7'($urandom_range(0, 30)) - 7'd15;
         model(rs, rt, rw, rh, m_mis, m_tr, m_nw);
         run_one($sformatf("rnd%0d", n), rnd160(),
                 rw, rh, rs, rt, m_mis, m_tr, m_nw);
      end

      // Reset while the write pulse is high.
      idx0 = rnd160();
      push(idx0, 48'h0, 16'hFFFF, 7'h6C);
      push(rnd160(), 48'h0, 16'h0, 7'd1);
      res_valid = 1'b1;
      res_taken = 1'b1;
      step();
      res_valid = 1'b0;
      step();
      step();
      chk("rw.en", upd_en, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rw.en_drop", upd_en, 0);
      chk("rw.idx", upd_index, 0);
      chk("rw.w", upd_weights, 0);
      chk("rw.occ", occupancy, 0);
      chk("rw.theta", theta_cur, THETA);
      #2;
      rst = 1'b0;
      step();
      chk("rw.after", upd_en, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
